// File: rtl/lane_aligner.sv
// Two-lane byte deskew: waits for the lagging lane, then pairs it with the leader's
// delayed bytes into one 16-bit word per cycle for the remainder of the burst.
module lane_aligner #(
  parameter int MAX_SKEW = 3
) (
  input  logic        rxbyteclkhs,
  input  logic        reset,
  input  logic [7:0]  lane0_byte,
  input  logic        lane0_valid,
  input  logic [7:0]  lane1_byte,
  input  logic        lane1_valid,
  output logic [15:0] out_stream,
  output logic        out_stream_valid,
  output logic        align_error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ALIGNED = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;
  localparam logic [3:0] MAX_SKEW_W = 4'(MAX_SKEW);

  logic [1:0]  state_r;
  logic        leader_r;
  logic [2:0]  k_r;
  logic [2:0]  skew_r;
  logic [15:0] out_stream_r;
  logic        out_valid_r;
  logic        align_error_r;

  // Entry 0 is the live input; entry i is the lane as it was i cycles ago.
  logic [8:0]  line0_s [0:MAX_SKEW];
  logic [8:0]  line1_s [0:MAX_SKEW];

  logic [3:0]  k_inc_s;
  logic [2:0]  tap_depth_s;
  logic [8:0]  lead_tap_s;
  logic        lead_v_s;
  logic        lag_v_s;
  logic [7:0]  lag_byte_s;
  logic [15:0] word_s;

  assign line0_s[0] = {lane0_valid, lane0_byte};
  assign line1_s[0] = {lane1_valid, lane1_byte};

  generate
    for (genvar g = 1; g <= MAX_SKEW; g++) begin : g_stage
      logic [8:0] stage0_r;
      logic [8:0] stage1_r;

      // One shift stage of each lane's delay line.
      always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
          stage0_r <= 9'h000;
          stage1_r <= 9'h000;
        end else begin
          stage0_r <= line0_s[g-1];
          stage1_r <= line1_s[g-1];
        end
      end

      assign line0_s[g] = stage0_r;
      assign line1_s[g] = stage1_r;
    end
  endgenerate

  assign lead_v_s   = leader_r ? lane1_valid : lane0_valid;
  assign lag_v_s    = leader_r ? lane0_valid : lane1_valid;
  assign lag_byte_s = leader_r ? lane0_byte  : lane1_byte;
  // At depth 0 (IDLE) both halves are live inputs, so a stale leader_r is harmless.
  assign word_s     = leader_r ? {lead_tap_s[7:0], lag_byte_s} : {lag_byte_s, lead_tap_s[7:0]};

  // Select how far back the leader is read: the candidate skew while waiting, the learned skew once aligned.
  always_comb begin
    k_inc_s = {1'b0, k_r} + 4'd1;
    case (state_r)
      ST_WAIT:    tap_depth_s = (k_inc_s > MAX_SKEW_W) ? MAX_SKEW_W[2:0] : k_inc_s[2:0];
      ST_ALIGNED: tap_depth_s = skew_r;
      default:    tap_depth_s = 3'd0;
    endcase
  end

  // Leader delay-line tap mux.
  always_comb begin
    lead_tap_s = 9'h000;
    for (int i = 0; i <= MAX_SKEW; i++) begin
      lead_tap_s = lead_tap_s |
                   ((tap_depth_s == 3'(i)) ? (leader_r ? line1_s[i] : line0_s[i]) : 9'h000);
    end
  end

  // Alignment FSM with registered word, valid and error outputs.
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      leader_r      <= 1'b0;
      k_r           <= 3'd0;
      skew_r        <= 3'd0;
      out_stream_r  <= 16'h0000;
      out_valid_r   <= 1'b0;
      align_error_r <= 1'b0;
    end else begin
      align_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          if (lane0_valid && lane1_valid) begin
            state_r      <= ST_ALIGNED;
            leader_r     <= 1'b0;
            skew_r       <= 3'd0;
            k_r          <= 3'd0;
            out_stream_r <= word_s;
            out_valid_r  <= 1'b1;
          end else if (lane0_valid || lane1_valid) begin
            state_r  <= ST_WAIT;
            leader_r <= lane1_valid;
            k_r      <= 3'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          out_valid_r <= 1'b0;
          if (lag_v_s && (k_inc_s <= MAX_SKEW_W)) begin
            state_r      <= ST_ALIGNED;
            skew_r       <= k_inc_s[2:0];
            out_stream_r <= word_s;
            out_valid_r  <= 1'b1;
          end else if (!lead_v_s) begin
            state_r <= ST_IDLE;
          end else if (k_inc_s > MAX_SKEW_W) begin
            state_r       <= ST_DRAIN;
            align_error_r <= 1'b1;
          end else begin
            k_r <= k_inc_s[2:0];
          end
        end
        ST_ALIGNED: begin
          if (lead_tap_s[8] && lag_v_s) begin
            out_stream_r <= word_s;
            out_valid_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b0;
            state_r     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          out_valid_r <= 1'b0;
          if (!lane0_valid && !lane1_valid) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_stream       = out_stream_r;
  assign out_stream_valid = out_valid_r;
  assign align_error      = align_error_r;

endmodule

// File: tb/tb_lane_aligner.sv
// Self-checking bench for lane_aligner: directed burst table, reset-mid-burst
// sequence and randomized bursts against a burst-level reference model.
module tb_lane_aligner;

  localparam int MAX_SKEW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  lane0_byte, lane1_byte;
  logic        lane0_valid, lane1_valid;
  logic [15:0] out_stream;
  logic        out_stream_valid;
  logic        align_error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] last_word_m;

  typedef struct {
    int          st0;
    int          n0;
    int          st1;
    int          n1;
    int          gap;
    int          exp_words;
    bit          exp_err;
    logic [63:0] b0;
    logic [63:0] b1;
  } burst_t;

  burst_t tbl [0:7];

  always #5 clk = ~clk;

  lane_aligner #(.MAX_SKEW(MAX_SKEW)) dut (
    .rxbyteclkhs      (clk),
    .reset            (reset),
    .lane0_byte       (lane0_byte),
    .lane0_valid      (lane0_valid),
    .lane1_byte       (lane1_byte),
    .lane1_valid      (lane1_valid),
    .out_stream       (out_stream),
    .out_stream_valid (out_stream_valid),
    .align_error      (align_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [7:0] b0, input logic v1,
                      input logic [7:0] b1, input logic rst);
    lane0_valid = v0;
    lane0_byte  = b0;
    lane1_valid = v1;
    lane1_byte  = b1;
    reset       = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " valid"}, 32'(out_stream_valid), 32'd0);
    check({name, " word"},  32'(out_stream), 32'(last_word_m));
    check({name, " error"}, 32'(align_error), 32'd0);
  endtask

  // Drive one burst and compare every cycle with the burst-level expectation.
  task automatic run_burst(input burst_t r, input int id);
    int end0, end1, t_total, first, lead_start, idx;
    logic v0, v1, exp_v, exp_e;
    logic [7:0] d0, d1;
    end0 = (r.n0 > 0) ? r.st0 + r.n0 : 0;
    end1 = (r.n1 > 0) ? r.st1 + r.n1 : 0;
    t_total = ((end0 > end1) ? end0 : end1) + r.gap;
    first = (r.st0 > r.st1) ? r.st0 : r.st1;
    if (r.n1 == 0) lead_start = r.st0;
    else if (r.n0 == 0) lead_start = r.st1;
    else lead_start = (r.st0 < r.st1) ? r.st0 : r.st1;
    for (int t = 0; t < t_total; t++) begin
      v0 = (r.n0 > 0) && (t >= r.st0) && (t < end0);
      v1 = (r.n1 > 0) && (t >= r.st1) && (t < end1);
      if (v0) d0 = r.b0[(t - r.st0) * 8 +: 8];
      else    d0 = 8'($urandom);
      if (v1) d1 = r.b1[(t - r.st1) * 8 +: 8];
      else    d1 = 8'($urandom);
      step(v0, d0, v1, d1, 1'b0);
      exp_v = (r.exp_words > 0) && (t >= first) && (t < first + r.exp_words);
      if (exp_v) begin
        idx = t - first;
        last_word_m = {r.b1[idx * 8 +: 8], r.b0[idx * 8 +: 8]};
      end
      exp_e = r.exp_err && (t == lead_start + MAX_SKEW + 1);
      check($sformatf("b%0d t%0d valid", id, t), 32'(out_stream_valid), 32'(exp_v));
      check($sformatf("b%0d t%0d word", id, t),  32'(out_stream), 32'(last_word_m));
      check($sformatf("b%0d t%0d error", id, t), 32'(align_error), 32'(exp_e));
    end
  endtask

  initial begin
    burst_t r;
    int s, nlead, nlag;
    bit lead1;

    // Zero skew (B8,11,22 / B8,33,44).
    tbl[0] = '{0, 3, 0, 3, 3, 3, 1'b0, 64'h0000_0000_0022_11B8, 64'h0000_0000_0044_33B8};
    // Lane 1 leads by 2.
    tbl[1] = '{2, 5, 0, 5, 3, 5, 1'b0, 64'h0000_0004_0302_01B8, 64'h0000_00DD_CCBB_AAB8};
    // Lane 1 arrives 5 cycles late: skew violation.
    tbl[2] = '{0, 8, 5, 4, 3, 0, 1'b1, 64'h7766_5544_3322_11B8, 64'h0000_0000_9988_BBB8};
    // Lone lane 0 for 4 cycles.
    tbl[3] = '{0, 4, 0, 0, 3, 0, 1'b0, 64'h0000_0000_0302_01B8, 64'h0000_0000_0000_0000};
    // Back-to-back: skew 1 then skew 3 with 2 idle cycles between.
    tbl[4] = '{0, 4, 1, 4, 2, 4, 1'b0, 64'h0000_0000_1312_11B8, 64'h0000_0000_2322_21B8};
    tbl[5] = '{3, 4, 0, 4, 3, 4, 1'b0, 64'h0000_0000_5352_51B8, 64'h0000_0000_6362_61B8};
    // Unequal lengths, zero skew.
    tbl[6] = '{0, 2, 0, 5, 3, 2, 1'b0, 64'h0000_0000_0000_E1B8, 64'h0000_00F4_F3F2_F1B8};
    // Skew MAX_SKEW+1 with lane 1 leading.
    tbl[7] = '{4, 3, 0, 6, 3, 0, 1'b1, 64'h0000_0000_00C3_C2C1, 64'h0000_D6D5_D4D3_D2D1};

    last_word_m = 16'h0000;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_idle_outputs("reset");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check_idle_outputs("post-reset idle");

    for (int i = 0; i < 8; i++) run_burst(tbl[i], i);

    // Reset while the third word of the skew-2 burst is on the output.
    for (int t = 0; t < 5; t++) begin
      step(t >= 2, (t >= 2) ? tbl[1].b0[(t - 2) * 8 +: 8] : 8'h00,
           1'b1, tbl[1].b1[t * 8 +: 8], 1'b0);
    end
    check("rst-mid third word", 32'(out_stream), 32'h0000_BB02);
    check("rst-mid third valid", 32'(out_stream_valid), 32'd1);
    step(1'b1, 8'h03, 1'b1, 8'hDD, 1'b1);
    last_word_m = 16'h0000;
    check_idle_outputs("rst-mid");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check_idle_outputs("rst-mid release");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    run_burst(tbl[0], 100);

    // Random bursts; expectations follow the skew/length rules only.
    for (int n = 0; n < 40; n++) begin
      s     = int'($urandom_range(MAX_SKEW + 2, 0));
      lead1 = 1'($urandom_range(1, 0));
      nlag  = int'($urandom_range(6, 1));
      if (s <= MAX_SKEW) nlead = int'($urandom_range(6, (s > 0) ? s : 1));
      else               nlead = int'($urandom_range(8, MAX_SKEW + 2));
      r.b0  = {$urandom, $urandom};
      r.b1  = {$urandom, $urandom};
      r.gap = int'($urandom_range(4, 2));
      if (lead1) begin
        r.st1 = 0; r.n1 = nlead; r.st0 = s; r.n0 = nlag;
      end else begin
        r.st0 = 0; r.n0 = nlead; r.st1 = s; r.n1 = nlag;
      end
      r.exp_words = (s <= MAX_SKEW) ? ((nlead < nlag) ? nlead : nlag) : 0;
      r.exp_err   = (s > MAX_SKEW);
      run_burst(r, 200 + n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_aligner.md
LANE_ALIGNER -- requirements
Module: lane_aligner

Interface
REQ-001 SHALL have parameter MAX_SKEW, default 3, maximum tolerated inter-lane skew in byte-clock cycles (legal 0..7).
REQ-002 SHALL have port rxbyteclkhs input 1, byte clock; the only clock.
REQ-003 SHALL have port reset input 1; reset is synchronous and active-high.
REQ-004 SHALL have port lane0_byte input 8, byte-aligned data from lane 0.
REQ-005 SHALL have port lane0_valid input 1, lane 0 byte valid (high from sync byte through end of burst).
REQ-006 SHALL have port lane1_byte input 8, byte-aligned data from lane 1.
REQ-007 SHALL have port lane1_valid input 1, lane 1 byte valid.
REQ-008 SHALL have port out_stream output 16, lane-aligned word: [7:0] lane 0 byte, [15:8] lane 1 byte.
REQ-009 SHALL have port out_stream_valid output 1, out_stream holds an aligned word.
REQ-010 SHALL have port align_error output 1, one-cycle pulse on skew violation.

Function
REQ-011 SHALL keep a per-lane delay line of MAX_SKEW+1 entries, each holding {valid, byte}, shifted every cycle.
REQ-012 SHALL implement states IDLE, WAIT, ALIGNED, DRAIN.
REQ-013 IDLE: lanes both low -> stay; exactly one lane valid -> WAIT, that lane = leader, skew counter k = 0; both valid at the same edge -> ALIGNED, k = 0, leader = lane 0.
REQ-014 WAIT: k increments by 1 each cycle the lagging lane stays low; lagging lane valid with k+1 <= MAX_SKEW -> ALIGNED with skew = k+1.
REQ-015 WAIT: k+1 would exceed MAX_SKEW -> DRAIN, align_error high for exactly one cycle, no output.
REQ-016 WAIT: leader valid drops before lagger arrives -> IDLE, no output, no error.
REQ-017 ALIGNED: leader byte SHALL be taken from the delay-line tap at depth skew; lagger byte from the current input (tap 0).
REQ-018 out_stream and out_stream_valid SHALL be registered: the word built from the lagger's first byte appears the cycle after that byte is sampled (latency 1 from the lagging lane).
REQ-019 ALIGNED: out_stream_valid = delayed leader valid AND lagger valid, registered; first cycle where either is low -> out_stream_valid low next cycle and -> DRAIN.
REQ-020 DRAIN: out_stream_valid held low; both raw lane valids low -> IDLE; any other input ignored.
REQ-021 out_stream SHALL hold its last value when out_stream_valid is low.
REQ-022 out_stream_valid SHALL never toggle high again within one burst; one contiguous valid window per burst.
REQ-023 Skew counter width SHALL be 3 bits; no wrap is possible since WAIT exits at MAX_SKEW.
REQ-024 align_error SHALL not assert in any state other than on the WAIT->DRAIN transition.

Reset
REQ-025 On reset sampled high: state IDLE, delay lines cleared to {0, 8'h00}, k = 0, out_stream = 16'h0000, out_stream_valid = 0, align_error = 0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-burst in ALIGNED; the next burst after reset release SHALL be aligned fresh from IDLE.

Verification
REQ-027 Zero skew: both lanes valid same edge, lane0 B8,11,22 / lane1 B8,33,44 -> one cycle later out_stream B8B8, 3311, 4422 contiguous, then valid low.
REQ-028 Skew 2: lane1 leads by 2 cycles with B8,AA,BB,CC,DD; lane0 B8,01,02,03,04 -> words B8B8, AA01, BB02, CC03, DD04; no error.
REQ-029 Skew violation, MAX_SKEW=3: lane0 valid, lane1 arrives 5 cycles later -> align_error single pulse, out_stream_valid stays 0, IDLE after both lanes low.
REQ-030 Lone lane: lane0 valid 4 cycles, lane1 never -> no output, no error, return to IDLE.
REQ-031 Reset mid-burst: assert reset during 3rd word of REQ-028 -> next cycle outputs all zero; subsequent zero-skew burst aligns correctly.
REQ-032 Back-to-back bursts: skew 1 burst then skew 3 burst with 2 idle cycles between -> both aligned correctly; skew relearned per burst.
